// File: rtl/isa_pkg.sv
// Shared ISA constants for fetch, decode and execute.
// Word widths, memory size, bubble word and instruction field positions.
package isa_pkg;

    localparam int ISA_WIDTH = 32;
    localparam int ISA_MEM_SIZE = 128;
    localparam int ISA_RESET_PC = 0;
    localparam logic [31:0] ISA_NOP_WORD = 32'h0000_0000;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC mux and instruction memory range check.
// Ports: clka/rsta, redirect_i + redirect_pc_i, hold_i -> pc_o, in_range_o.
module pc_reg
    import isa_pkg::*;
#(
    parameter int WIDTH = ISA_WIDTH,
    parameter int MEM_SIZE = ISA_MEM_SIZE,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(ISA_RESET_PC)
) (
    input  logic             clka,
    input  logic             rsta,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    input  logic             hold_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             in_range_o
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    // redirect_i arrives already qualified against a held fault
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (!hold_i) begin
            pc_d = pc_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;
    assign in_range_o = (pc_q < WIDTH'(MEM_SIZE));

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, instruction memory address, IF/ID register, fault flag.
// Ports: clka/rsta, stall_i, redirect_i/redirect_pc_i, imem_*, ifid_*, fault_o.
module instr_fetch_stage
    import isa_pkg::*;
#(
    parameter int WIDTH = ISA_WIDTH,
    parameter int MEM_SIZE = ISA_MEM_SIZE,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(ISA_RESET_PC),
    parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(ISA_NOP_WORD)
) (
    input  logic             clka,
    input  logic             rsta,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic [WIDTH-1:0] imem_data_i,
    output logic [WIDTH-1:0] ifid_instr_o,
    output logic [WIDTH-1:0] ifid_pc_o,
    output logic [WIDTH-1:0] ifid_pc_plus1_o,
    output logic             ifid_valid_o,
    output logic             fault_o
);

    logic [WIDTH-1:0] pc;
    logic             in_range;
    logic             redir_en;
    logic             pc_hold;

    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] ipc_q, ipc_d;
    logic [WIDTH-1:0] ipc1_q, ipc1_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;

    // a held fault freezes the PC and swallows redirects
    assign redir_en = redirect_i & ~fault_q;
    assign pc_hold = fault_q | ~in_range | stall_i;

    pc_reg #(
        .WIDTH(WIDTH),
        .MEM_SIZE(MEM_SIZE),
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clka(clka),
        .rsta(rsta),
        .redirect_i(redir_en),
        .redirect_pc_i(redirect_pc_i),
        .hold_i(pc_hold),
        .pc_o(pc),
        .in_range_o(in_range)
    );

    always_comb begin
        instr_d = instr_q;
        ipc_d = ipc_q;
        ipc1_d = ipc1_q;
        valid_d = valid_q;
        fault_d = fault_q;
        if (fault_q) begin
            valid_d = 1'b0;
        end else if (redirect_i) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else if (!in_range) begin
            fault_d = 1'b1;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            instr_d = imem_data_i;
            ipc_d = pc;
            ipc1_d = pc + WIDTH'(1);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            instr_q <= NOP_WORD;
            ipc_q <= '0;
            ipc1_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            ipc_q <= ipc_d;
            ipc1_q <= ipc1_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign imem_addr_o = pc;
    assign ifid_instr_o = instr_q;
    assign ifid_pc_o = ipc_q;
    assign ifid_pc_plus1_o = ipc1_q;
    assign ifid_valid_o = valid_q;
    assign fault_o = fault_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a combinational memory model.
// Scenarios: reset/run, stall, redirect, redirect+stall, fault, reset.
module tb_instr_fetch_stage;

    logic        clka = 1'b0;
    logic        rsta = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc_plus1_o;
    logic        ifid_valid_o;
    logic        fault_o;

    logic [31:0] mem [0:127];
    int total = 0;
    int bad = 0;

    always #5 clka = ~clka;

    assign imem_data_i = (imem_addr_o < 32'd128) ? mem[imem_addr_o[6:0]] : 32'hDEAD_BEEF;

    instr_fetch_stage dut (
        .clka(clka),
        .rsta(rsta),
        .stall_i(stall_i),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_addr_o(imem_addr_o),
        .imem_data_i(imem_data_i),
        .ifid_instr_o(ifid_instr_o),
        .ifid_pc_o(ifid_pc_o),
        .ifid_pc_plus1_o(ifid_pc_plus1_o),
        .ifid_valid_o(ifid_valid_o),
        .fault_o(fault_o)
    );

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic test_reset();
        rsta = 1'b1;
        tick();
        tick();
        total++;
        if ({imem_addr_o, ifid_instr_o, ifid_pc_o, ifid_pc_plus1_o} !== 128'd0 ||
            {ifid_valid_o, fault_o} !== 2'b00) begin
            bad++;
            $display("FAIL reset_state pc=%0d instr=%h ipc=%0d ipc1=%0d v=%b f=%b exp all 0",
                     imem_addr_o, ifid_instr_o, ifid_pc_o, ifid_pc_plus1_o,
                     ifid_valid_o, fault_o);
        end
    endtask

    task automatic test_run();
        rsta = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++;
            if (imem_addr_o !== 32'(k) || ifid_pc_o !== 32'(k - 1) ||
                ifid_pc_plus1_o !== 32'(k) || ifid_valid_o !== 1'b1) begin
                bad++;
                $display("FAIL run_%0d got pc=%0d ipc=%0d ipc1=%0d v=%b exp pc=%0d ipc=%0d v=1",
                         k, imem_addr_o, ifid_pc_o, ifid_pc_plus1_o, ifid_valid_o, k, k - 1);
            end
            if (k == 3) begin
                total++;
                if (ifid_instr_o !== 32'h0601_0001) begin
                    bad++;
                    $display("FAIL run_instr_pc2 got=%h exp=06010001", ifid_instr_o);
                end
            end
        end
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (imem_addr_o !== 32'd5 || ifid_pc_o !== 32'd4 ||
                ifid_valid_o !== 1'b1 || ifid_instr_o !== 32'h1000_0004) begin
                bad++;
                $display("FAIL stall_%0d got pc=%0d ipc=%0d v=%b instr=%h exp 5 4 1 10000004",
                         k, imem_addr_o, ifid_pc_o, ifid_valid_o, ifid_instr_o);
            end
        end
        stall_i = 1'b0;
        tick();
        total++;
        if (imem_addr_o !== 32'd6 || ifid_pc_o !== 32'd5 || ifid_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL stall_release got pc=%0d ipc=%0d v=%b exp 6 5 1",
                     imem_addr_o, ifid_pc_o, ifid_valid_o);
        end
    endtask

    task automatic test_redirect();
        for (int k = 0; k < 18; k++) tick();
        total++;
        if (imem_addr_o !== 32'd24) begin
            bad++;
            $display("FAIL redir_pre got pc=%0d exp 24", imem_addr_o);
        end
        redirect_i = 1'b1;
        redirect_pc_i = 32'd19;
        tick();
        redirect_i = 1'b0;
        total++;
        if (imem_addr_o !== 32'd19 || ifid_valid_o !== 1'b0 ||
            ifid_instr_o !== 32'd0 || ifid_pc_o !== 32'd23) begin
            bad++;
            $display("FAIL redir_bubble got pc=%0d v=%b instr=%h ipc=%0d exp 19 0 0 23",
                     imem_addr_o, ifid_valid_o, ifid_instr_o, ifid_pc_o);
        end
        tick();
        total++;
        if (ifid_pc_o !== 32'd19 || ifid_pc_plus1_o !== 32'd20 ||
            ifid_valid_o !== 1'b1 || ifid_instr_o !== 32'h1000_0013) begin
            bad++;
            $display("FAIL redir_target got ipc=%0d ipc1=%0d v=%b instr=%h exp 19 20 1 10000013",
                     ifid_pc_o, ifid_pc_plus1_o, ifid_valid_o, ifid_instr_o);
        end
    endtask

    task automatic test_redirect_stall();
        redirect_i = 1'b1;
        stall_i = 1'b1;
        redirect_pc_i = 32'd9;
        tick();
        redirect_i = 1'b0;
        stall_i = 1'b0;
        total++;
        if (imem_addr_o !== 32'd9 || ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'd0) begin
            bad++;
            $display("FAIL redir_stall got pc=%0d v=%b instr=%h exp 9 0 0",
                     imem_addr_o, ifid_valid_o, ifid_instr_o);
        end
        tick();
        total++;
        if (ifid_pc_o !== 32'd9 || ifid_valid_o !== 1'b1 || imem_addr_o !== 32'd10) begin
            bad++;
            $display("FAIL redir_stall_next got ipc=%0d v=%b pc=%0d exp 9 1 10",
                     ifid_pc_o, ifid_valid_o, imem_addr_o);
        end
    endtask

    task automatic test_fault();
        redirect_i = 1'b1;
        redirect_pc_i = 32'd127;
        tick();
        redirect_i = 1'b0;
        tick();
        total++;
        if (ifid_pc_o !== 32'd127 || ifid_valid_o !== 1'b1 ||
            ifid_instr_o !== 32'h1000_007F || imem_addr_o !== 32'd128 || fault_o !== 1'b0) begin
            bad++;
            $display("FAIL fault_last got ipc=%0d v=%b instr=%h pc=%0d f=%b exp 127 1 1000007f 128 0",
                     ifid_pc_o, ifid_valid_o, ifid_instr_o, imem_addr_o, fault_o);
        end
        tick();
        total++;
        if (fault_o !== 1'b1 || ifid_valid_o !== 1'b0 ||
            imem_addr_o !== 32'd128 || ifid_instr_o !== 32'd0) begin
            bad++;
            $display("FAIL fault_set got f=%b v=%b pc=%0d instr=%h exp 1 0 128 0",
                     fault_o, ifid_valid_o, imem_addr_o, ifid_instr_o);
        end
        redirect_i = 1'b1;
        redirect_pc_i = 32'd0;
        tick();
        redirect_i = 1'b0;
        tick();
        total++;
        if (fault_o !== 1'b1 || imem_addr_o !== 32'd128 || ifid_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL fault_sticky got f=%b pc=%0d v=%b exp 1 128 0",
                     fault_o, imem_addr_o, ifid_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        rsta = 1'b1;
        tick();
        rsta = 1'b0;
        total++;
        if (fault_o !== 1'b0 || imem_addr_o !== 32'd0) begin
            bad++;
            $display("FAIL fault_clear got f=%b pc=%0d exp 0 0", fault_o, imem_addr_o);
        end
        for (int k = 0; k < 12; k++) tick();
        total++;
        if (imem_addr_o !== 32'd12 || ifid_pc_o !== 32'd11) begin
            bad++;
            $display("FAIL mid_pre got pc=%0d ipc=%0d exp 12 11", imem_addr_o, ifid_pc_o);
        end
        rsta = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'd30;
        tick();
        rsta = 1'b0;
        redirect_i = 1'b0;
        total++;
        if ({imem_addr_o, ifid_instr_o, ifid_pc_o, ifid_pc_plus1_o} !== 128'd0 ||
            {ifid_valid_o, fault_o} !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid pc=%0d instr=%h ipc=%0d ipc1=%0d v=%b f=%b exp all 0",
                     imem_addr_o, ifid_instr_o, ifid_pc_o, ifid_pc_plus1_o,
                     ifid_valid_o, fault_o);
        end
        tick();
        total++;
        if (imem_addr_o !== 32'd1 || ifid_pc_o !== 32'd0 ||
            ifid_valid_o !== 1'b1 || ifid_instr_o !== 32'h1000_0000) begin
            bad++;
            $display("FAIL reset_mid_run got pc=%0d ipc=%0d v=%b instr=%h exp 1 0 1 10000000",
                     imem_addr_o, ifid_pc_o, ifid_valid_o, ifid_instr_o);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 | 32'(i);
        mem[2] = 32'h0601_0001;
        test_reset();
        test_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_fault();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
